// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the cpu_sequencer datapath slice.
// BRANCH_LUT is only consulted when SEQ_BRANCH_LUT_EN is defined.
package definitions;

   typedef enum logic [2:0] {ADD, XOR, AND, RSL, MOV, LD, ST, BLQZ} aluOp;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, DONE} seq_state_t;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   // Absolute branch targets; truncated to the sequencer's PC width on use.
   localparam logic [15:0] BRANCH_LUT [8] = '{
      16'h0000, 16'h0010, 16'h0200, 16'h0040,
      16'h0100, 16'h0080, 16'h03F0, 16'h03FF
   };

endpackage

// File: rtl/cpu_sequencer_branch_target.sv
// Combinational BLQZ target: absolute LUT entry when SEQ_BRANCH_LUT_EN is
// defined, otherwise pc plus the sign-extended 3-bit rb field.
module branch_target
   import definitions::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic [PC_W-1:0] pc_i,
   input  logic [2:0]      rb_addr_i,
   output logic [PC_W-1:0] target_o
);

`ifdef SEQ_BRANCH_LUT_EN
   logic unused_pc;
   assign unused_pc = ^pc_i;

   always_comb begin
      target_o = PC_W'(BRANCH_LUT[rb_addr_i]);
   end
`else
   always_comb begin
      target_o = pc_i + {{(PC_W-3){rb_addr_i[2]}}, rb_addr_i};
   end
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for the 8-bit datapath.
// Build option: SEQ_BRANCH_LUT_EN selects LUT-based absolute BLQZ targets.
module cpu_sequencer
   import definitions::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [8:0]      instr,
   input  logic            jump_flag,
   output logic [PC_W-1:0] pc,
   output logic [2:0]      alu_op,
   output logic [2:0]      ra_addr,
   output logic [2:0]      rb_addr,
   output logic            reg_we,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            busy,
   output logic            done
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] target;
   logic [8:0]      ir_q, ir_d;
   aluOp            op;

   assign op     = aluOp'(ir_q[8:6]);
   assign pc_inc = pc_q + 1'b1;
   assign pc     = pc_q;

   branch_target #(.PC_W(PC_W)) u_branch_target (
      .pc_i      (pc_q),
      .rb_addr_i (ir_q[2:0]),
      .target_o  (target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      alu_op  = '0;
      ra_addr = '0;
      rb_addr = '0;
      reg_we  = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (instr == HALT_INSTR) begin
               state_d = DONE;
            end else begin
               ir_d    = instr;
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (op)
               LD, ST:  state_d = MEM;
               BLQZ: begin
                  pc_d    = jump_flag ? target : pc_inc;
                  state_d = FETCH;
               end
               default: state_d = WB;
            endcase
         end
         MEM: begin
            // Only LD and ST ever reach MEM.
            if (op == LD) begin
               mem_rd  = 1'b1;
               state_d = WB;
            end else begin
               mem_wr  = 1'b1;
               pc_d    = pc_inc;
               state_d = FETCH;
            end
         end
         WB: begin
            reg_we  = 1'b1;
            pc_d    = pc_inc;
            state_d = FETCH;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase

      // Decode fields stay on the ALU through write-back.
      if (state_q inside {EXEC, MEM, WB}) begin
         alu_op  = ir_q[8:6];
         ra_addr = ir_q[5:3];
         rb_addr = ir_q[2:0];
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer against an
// instruction-level reference model that expands each instruction into cycles.
module tb_cpu_sequencer;
   import definitions::*;

   localparam int unsigned PC_W  = 10;
   localparam int          DEPTH = 1 << PC_W;

   logic            clk = 1'b0;
   logic            rst_n, start, jump_flag;
   logic [8:0]      instr;
   logic [PC_W-1:0] pc;
   logic [2:0]      alu_op, ra_addr, rb_addr;
   logic            reg_we, mem_rd, mem_wr, busy, done;

   logic [8:0] imem [DEPTH];
   assign instr = imem[pc];

   cpu_sequencer #(.PC_W(PC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .instr     (instr),
      .jump_flag (jump_flag),
      .pc        (pc),
      .alu_op    (alu_op),
      .ra_addr   (ra_addr),
      .rb_addr   (rb_addr),
      .reg_we    (reg_we),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {pc, alu_op, ra, rb, reg_we, mem_rd, mem_wr, busy, done}
   function automatic logic [31:0] pk(int p, int op, int ra, int rb,
                                      bit we, bit rd, bit wr, bit bz, bit dn);
      return {8'd0, 10'(p), 3'(op), 3'(ra), 3'(rb), we, rd, wr, bz, dn};
   endfunction

   function automatic logic [31:0] obs_vec();
      return {8'd0, pc, alu_op, ra_addr, rb_addr, reg_we, mem_rd, mem_wr, busy, done};
   endfunction

   typedef struct {
      logic [31:0] exp;
      bit          jf;
   } cyc_t;

   cyc_t q[$];

   function automatic int branch_dest(int p, int rb);
`ifdef SEQ_BRANCH_LUT_EN
      return int'(BRANCH_LUT[rb]) % DEPTH;
`else
      int off;
      off = (rb >= 4) ? rb - 8 : rb;
      return (p + off + DEPTH) % DEPTH;
`endif
   endfunction

   // Instruction-level execution from pc 0; jf_mode 0 = random, 1 = taken, 2 = not taken.
   task automatic build(input int max_cyc, input int jf_mode);
      int p, op, ra, rb;
      logic [8:0] w;
      bit jf;
      p = 0;
      q.delete();
      while (q.size() < max_cyc) begin
         w  = imem[p];
         op = int'(w[8:6]);
         ra = int'(w[5:3]);
         rb = int'(w[2:0]);
         q.push_back('{exp: pk(p, 0, 0, 0, 0, 0, 0, 1, 0), jf: 1'($urandom)});
         if (w == 9'h1FF) begin
            q.push_back('{exp: pk(p, 0, 0, 0, 0, 0, 0, 0, 1), jf: 1'($urandom)});
            q.push_back('{exp: pk(p, 0, 0, 0, 0, 0, 0, 0, 1), jf: 1'($urandom)});
            break;
         end
         jf = (jf_mode == 0) ? 1'($urandom) : (jf_mode == 1);
         q.push_back('{exp: pk(p, op, ra, rb, 0, 0, 0, 1, 0), jf: jf});
         if (op <= 4) begin
            q.push_back('{exp: pk(p, op, ra, rb, 1, 0, 0, 1, 0), jf: 1'($urandom)});
            p = (p + 1) % DEPTH;
         end else if (op == 5) begin
            q.push_back('{exp: pk(p, op, ra, rb, 0, 1, 0, 1, 0), jf: 1'($urandom)});
            q.push_back('{exp: pk(p, op, ra, rb, 1, 0, 0, 1, 0), jf: 1'($urandom)});
            p = (p + 1) % DEPTH;
         end else if (op == 6) begin
            q.push_back('{exp: pk(p, op, ra, rb, 0, 0, 1, 1, 0), jf: 1'($urandom)});
            p = (p + 1) % DEPTH;
         end else begin
            p = jf ? branch_dest(p, rb) : (p + 1) % DEPTH;
         end
      end
   endtask

   task automatic run(input string tag, input bit noise);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (q[i]) begin
         check($sformatf("%s[%0d]", tag, i), obs_vec(), q[i].exp);
         jump_flag = q[i].jf;
         start     = noise && q[i].exp[1] && ($urandom_range(3) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check(tag, obs_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic fill(input logic [8:0] w);
      for (int i = 0; i < DEPTH; i++) imem[i] = w;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      jump_flag = 1'b0;
      fill(9'h100);
      #1;
      check("reset_state", obs_vec(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_hold", obs_vec(), 32'd0);

      // ADD r1,r2 ; HALT, then restart straight from DONE
      imem[0] = 9'h00A;
      imem[1] = 9'h1FF;
      build(40, 0);
      run("alu", 1'b0);
      run("restart", 1'b0);

      // LD r3,r4 ; ST r3,r5 ; HALT
      do_reset("rst_ldst");
      imem[0] = 9'h15C;
      imem[1] = 9'h19D;
      imem[2] = 9'h1FF;
      build(40, 0);
      run("ldst", 1'b1);

      // BLQZ at pc 5 with rb = -2, taken then not taken
      do_reset("rst_br");
      fill(9'h100);
      imem[5] = 9'h1C6;
      imem[6] = 9'h1FF;
      build(30, 1);
      run("br_taken", 1'b1);
      do_reset("rst_br_nt");
      build(30, 2);
      run("br_not_taken", 1'b1);

      // BLQZ rb=2 (LUT entry 10'h200 or relative +2)
      do_reset("rst_lut");
      fill(9'h100);
      imem[0]      = 9'h1C2;
      imem[2]      = 9'h1FF;
      imem[10'h200] = 9'h1FF;
      build(20, 1);
      run("br_rb2", 1'b1);

      // Branch to 10'h3FF, then pc wraps to 0 and loops
      do_reset("rst_wrap");
      fill(9'h100);
      imem[0] = 9'h1C7;
      build(16, 1);
      run("wrap", 1'b1);

      // Reset during WB of ADD
      do_reset("rst_wb_pre");
      imem[0] = 9'h00A;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("wb_before_reset", obs_vec(), pk(0, 0, 1, 2, 1, 0, 0, 1, 0));
      do_reset("reset_mid_wb");

      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            imem[i] = 9'($urandom);
            if ($urandom_range(7) == 0) imem[i] = 9'h1FF;
         end
         build(80, 0);
         run($sformatf("rand%0d", it), 1'b1);
         do_reset($sformatf("rand_rst%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
